// File: rtl/hash_req_dispatch.sv
// Request dispatcher between the show-ahead request FIFO and the hashtable core.
// Two-register pipeline (S1 popped word, S2 output), drops op=11 words, computes a multiplicative bucket index.
module hash_req_dispatch #(
    parameter int KEY_WIDTH  = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int HASH_MULT  = 37
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [KEY_WIDTH+1:0]  fifo_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_op,
    output logic [KEY_WIDTH-1:0]  out_key,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  drained,
    output logic [15:0]           req_count,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic [1:0]            op;
        logic [KEY_WIDTH-1:0]  key;
        logic [ADDR_WIDTH-1:0] index;
    } req_t;

    localparam logic [KEY_WIDTH-1:0] MULT = KEY_WIDTH'(HASH_MULT);

    state_e               state_q, state_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [KEY_WIDTH+1:0] s1_word_q, s1_word_d;
    logic                 out_valid_q, out_valid_d;
    req_t                 out_q, out_d;
    logic                 drained_q, drained_d;
    logic [15:0]          req_cnt_q, req_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 s2_free, s1_adv, s1_ready, pop, hs, drop, load;
    logic [1:0]           s1_op;
    logic [KEY_WIDTH-1:0] s1_key, prod;

    assign s1_op    = s1_word_q[KEY_WIDTH+1:KEY_WIDTH];
    assign s1_key   = s1_word_q[KEY_WIDTH-1:0];
    assign prod     = s1_key * MULT;
    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign s1_ready = !s1_valid_q || s1_adv;
    assign pop      = (state_q == RUN) && !fifo_empty && s1_ready;
    assign hs       = out_valid_q && out_ready;
    assign drop     = s1_adv && (s1_op == 2'b11);
    assign load     = s1_adv && (s1_op != 2'b11);

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        req_cnt_d   = req_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (!s1_valid_q && (!out_valid_q || out_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        drained_d = (state_d == IDLE);

        // A pop refills S1 in the same cycle it advances, so no bubble appears.
        if (pop) begin
            s1_valid_d = 1'b1;
            s1_word_d  = fifo_data;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_d.op    = s1_op;
            out_d.key   = s1_key;
            out_d.index = prod[KEY_WIDTH-1 -: ADDR_WIDTH];
        end else if (hs) begin
            out_valid_d = 1'b0;
        end

        if (hs && req_cnt_q != 16'hFFFF)    req_cnt_d  = req_cnt_q + 16'd1;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            drained_q   <= 1'b1;
            req_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            drained_q   <= drained_d;
            req_cnt_q   <= req_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fifo_rd_en = pop;
    assign out_valid  = out_valid_q;
    assign out_op     = out_q.op;
    assign out_key    = out_q.key;
    assign out_index  = out_q.index;
    assign drained    = drained_q;
    assign req_count  = req_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_hash_req_dispatch.sv
// Directed bench for hash_req_dispatch: a small show-ahead FIFO model feeds it, a monitor logs handshakes.
module tb_hash_req_dispatch;
    localparam int KW = 6;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty;
    logic [KW+1:0] fifo_data;
    logic          fifo_rd_en, out_valid, drained;
    logic [1:0]    out_op;
    logic [KW-1:0] out_key;
    logic [AW-1:0] out_index;
    logic [15:0]   req_count, drop_count;

    hash_req_dispatch #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW), .HASH_MULT(37)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_key(out_key), .out_index(out_index), .drained(drained),
        .req_count(req_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0] fmem [0:63];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    assign fifo_data  = fmem[rp[5:0]];
    always @(posedge clk) if (fifo_rd_en) rp <= rp + 1;

    logic [11:0] got[$];
    always @(posedge clk) if (out_valid && out_ready) got.push_back({out_op, out_key, out_index});

    int nvec  = 0;
    int nfail = 0;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task push(input logic [7:0] w);
        fmem[wp[5:0]] = w;
        wp++;
    endtask

    task test_reset;
        #2 reset = 1'b0;
        tick(); tick();
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        nvec++; if (drained !== 1'b1) begin nfail++; $display("FAIL rst_drained got %b want 1", drained); end
        nvec++; if (fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL rst_rd_en got %b want 0", fifo_rd_en); end
        nvec++; if ({out_op, out_key, out_index} !== 12'h000) begin nfail++; $display("FAIL rst_out got %h want 000", {out_op, out_key, out_index}); end
        nvec++; if ({req_count, drop_count} !== 32'h0) begin nfail++; $display("FAIL rst_cnt got %h want 0", {req_count, drop_count}); end
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

    task test_single;
        push(8'h41);
        enable = 1'b1; out_ready = 1'b1;
        nvec++; if (fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL idle_no_pop got %b want 0", fifo_rd_en); end
        tick();
        nvec++; if (fifo_rd_en !== 1'b1) begin nfail++; $display("FAIL run_pop got %b want 1", fifo_rd_en); end
        nvec++; if (drained !== 1'b0) begin nfail++; $display("FAIL run_drained got %b want 0", drained); end
        tick();
        nvec++; if (out_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL s1_only got v=%b rd=%b want 0 0", out_valid, fifo_rd_en); end
        tick();
        nvec++; if ({out_valid, out_op, out_key, out_index} !== {1'b1, 2'b01, 6'd1, 4'd9}) begin
            nfail++; $display("FAIL single_out got v=%b op=%h key=%0d idx=%0d want 1 1 1 9", out_valid, out_op, out_key, out_index); end
        nvec++; if (req_count !== 16'd0) begin nfail++; $display("FAIL single_req_pre got %0d want 0", req_count); end
        tick();
        nvec++; if (out_valid !== 1'b0 || req_count !== 16'd1) begin nfail++; $display("FAIL single_hs got v=%b req=%0d want 0 1", out_valid, req_count); end
    endtask

    task test_back_to_back;
        push(8'h02); push(8'h3F); push(8'h80);
        tick(); tick();
        nvec++; if ({out_valid, out_op, out_key, out_index} !== {1'b1, 2'b00, 6'd2, 4'd2}) begin
            nfail++; $display("FAIL b2b_0 got v=%b op=%h key=%0d idx=%0d want 1 0 2 2", out_valid, out_op, out_key, out_index); end
        tick();
        nvec++; if ({out_valid, out_op, out_key, out_index} !== {1'b1, 2'b00, 6'd63, 4'd6}) begin
            nfail++; $display("FAIL b2b_1 got v=%b op=%h key=%0d idx=%0d want 1 0 63 6", out_valid, out_op, out_key, out_index); end
        tick();
        nvec++; if ({out_valid, out_op, out_key, out_index} !== {1'b1, 2'b10, 6'd0, 4'd0}) begin
            nfail++; $display("FAIL b2b_2 got v=%b op=%h key=%0d idx=%0d want 1 2 0 0", out_valid, out_op, out_key, out_index); end
        tick();
        nvec++; if (out_valid !== 1'b0 || req_count !== 16'd4) begin nfail++; $display("FAIL b2b_end got v=%b req=%0d want 0 4", out_valid, req_count); end
    endtask

    logic [11:0] bp_exp [4] = '{{2'b00, 6'd1, 4'd9}, {2'b00, 6'd2, 4'd2}, {2'b00, 6'd3, 4'd11}, {2'b00, 6'd4, 4'd5}};

    task test_backpressure;
        int r0, g0, n;
        out_ready = 1'b0;
        r0 = rp;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick();
        for (int c = 2; c <= 5; c++) begin
            tick();
            nvec++; if ({out_valid, out_op, out_key, out_index} !== {1'b1, 2'b00, 6'd1, 4'd9}) begin
                nfail++; $display("FAIL bp_hold c%0d got v=%b key=%0d idx=%0d want 1 1 9", c, out_valid, out_key, out_index); end
        end
        nvec++; if (rp - r0 !== 2) begin nfail++; $display("FAIL bp_pops got %0d want 2", rp - r0); end
        nvec++; if (fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL bp_rd_en got %b want 0", fifo_rd_en); end
        g0 = got.size();
        out_ready = 1'b1;
        n = 0;
        while (got.size() < g0 + 4 && n < 20) begin tick(); n++; end
        tick(); tick(); tick();
        nvec++; if (got.size() !== g0 + 4) begin nfail++; $display("FAIL bp_count got %0d want %0d", got.size() - g0, 4); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (g0 + i >= got.size() || got[g0 + i] !== bp_exp[i]) begin
                nfail++; $display("FAIL bp_word%0d got %h want %h", i, (g0 + i < got.size()) ? got[g0 + i] : 12'hxxx, bp_exp[i]); end
        end
        nvec++; if (req_count !== 16'd8) begin nfail++; $display("FAIL bp_req got %0d want 8", req_count); end
    endtask

    task test_drop;
        int g0;
        g0 = got.size();
        push(8'hC5); push(8'h41);
        repeat (6) tick();
        nvec++; if (drop_count !== 16'd1) begin nfail++; $display("FAIL drop_cnt got %0d want 1", drop_count); end
        nvec++; if (got.size() !== g0 + 1) begin nfail++; $display("FAIL drop_emitted got %0d want 1", got.size() - g0); end
        nvec++; if (got.size() < g0 + 1 || got[g0] !== {2'b01, 6'd1, 4'd9}) begin nfail++; $display("FAIL drop_word got %h want 419", (got.size() > g0) ? got[g0] : 12'hxxx); end
        nvec++; if (req_count !== 16'd9) begin nfail++; $display("FAIL drop_req got %0d want 9", req_count); end
    endtask

    task test_drain;
        int r0, g0, n;
        out_ready = 1'b0;
        r0 = rp; g0 = got.size();
        push(8'h05); push(8'h06); push(8'h07);
        tick(); tick();
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            nvec++; if (rp - r0 !== 2 || drained !== 1'b0 || fifo_rd_en !== 1'b0) begin
                nfail++; $display("FAIL drain_hold%0d got pops=%0d drained=%b rd=%b want 2 0 0", c, rp - r0, drained, fifo_rd_en); end
        end
        out_ready = 1'b1;
        n = 0;
        while (drained !== 1'b1 && n < 10) begin tick(); n++; end
        nvec++; if (drained !== 1'b1) begin nfail++; $display("FAIL drain_done got %b want 1", drained); end
        nvec++; if (rp - r0 !== 2) begin nfail++; $display("FAIL drain_pops got %0d want 2", rp - r0); end
        nvec++; if (got.size() !== g0 + 2 || got[g0] !== {2'b00, 6'd5, 4'd14} || got[g0 + 1] !== {2'b00, 6'd6, 4'd7}) begin
            nfail++; $display("FAIL drain_words got n=%0d", got.size() - g0); end
        enable = 1'b1;
        n = 0;
        while (got.size() < g0 + 3 && n < 10) begin tick(); n++; end
        nvec++; if (got.size() !== g0 + 3 || got[g0 + 2] !== {2'b00, 6'd7, 4'd0}) begin nfail++; $display("FAIL resume_word got n=%0d", got.size() - g0); end
        nvec++; if (rp - r0 !== 3 || req_count !== 16'd12) begin nfail++; $display("FAIL resume_cnt got pops=%0d req=%0d want 3 12", rp - r0, req_count); end
    endtask

    task test_async_reset;
        int n;
        out_ready = 1'b0;
        push(8'h08);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
        nvec++; if ({out_valid, out_key, out_index} !== {1'b1, 6'd8, 4'd10}) begin nfail++; $display("FAIL ar_pre got v=%b key=%0d idx=%0d want 1 8 10", out_valid, out_key, out_index); end
        #2 reset = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0 || drained !== 1'b1 || fifo_rd_en !== 1'b0) begin
            nfail++; $display("FAIL ar_async got v=%b drained=%b rd=%b want 0 1 0", out_valid, drained, fifo_rd_en); end
        nvec++; if ({req_count, drop_count} !== 32'h0) begin nfail++; $display("FAIL ar_cnt got req=%0d drop=%0d want 0 0", req_count, drop_count); end
        nvec++; if ({out_op, out_key, out_index} !== 12'h000) begin nfail++; $display("FAIL ar_out got %h want 000", {out_op, out_key, out_index}); end
        @(negedge clk) reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        nvec++; if (out_valid !== 1'b0 || req_count !== 16'd0) begin nfail++; $display("FAIL ar_discard got v=%b req=%0d want 0 0", out_valid, req_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_drain();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/hash_req_dispatch.md
# hash_req_dispatch

- Sits directly downstream of the request FIFO and consumes its show-ahead read port.
- Pops request words, discards malformed ones, and computes a multiplicative hash bucket index for each valid request.
- Presents each request to the hashtable core over a valid/ready handshake.
- Has an enable/drain state machine, so the table can be quiesced without losing popped words.

## Interface
Parameters:
- KEY_WIDTH, 6, key width; the FIFO word is KEY_WIDTH+2 bits (FIFO DATA_WIDTH = 8 by default).
- ADDR_WIDTH, 4, bucket index width; must satisfy 1 ≤ ADDR_WIDTH ≤ KEY_WIDTH.
- HASH_MULT, 37, odd multiplier, KEY_WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = dispatch requests; 0 = stop popping and drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  KEY_WIDTH+2  FIFO head word, valid whenever fifo_empty=0: [KEY_WIDTH+1:KEY_WIDTH]=op, [KEY_WIDTH-1:0]=key.
- fifo_rd_en  out  1  combinational pop strobe.
- out_valid  out  1  request valid toward the hashtable.
- out_ready  in  1  hashtable accepts the request.
- out_op  out  2  op code: 00 lookup, 01 insert, 10 delete.
- out_key  out  KEY_WIDTH  key.
- out_index  out  ADDR_WIDTH  bucket index.
- drained  out  1  high in IDLE.
- req_count  out  16  accepted requests, saturating.
- drop_count  out  16  dropped malformed words, saturating.

## Operation
- Two-register pipeline:
  - S1 holds the popped word (s1_valid, s1_word).
  - S2 is the output register (out_valid, out_op, out_key, out_index).
- s2_free = !out_valid || out_ready.
- s1_adv = s1_valid && s2_free.
- s1_ready = !s1_valid || s1_adv.
- fifo_rd_en = (state==RUN) && !fifo_empty && s1_ready. It is never asserted while the FIFO is empty.
- On a pop, S1 captures fifo_data and sets s1_valid=1. If S1 advances without a new pop, s1_valid=0.
- On s1_adv:
  - op ≠ 11: S2 loads op, key and index, and sets out_valid=1.
  - op = 11: the word is dropped and drop_count increments. S2 is not loaded; if out_ready was high, out_valid clears.
- If out_valid && out_ready and no new load occurs, out_valid=0.
- Hash: prod = (key * HASH_MULT) mod 2^KEY_WIDTH; index = prod[KEY_WIDTH-1 -: ADDR_WIDTH].
- req_count increments on every out_valid && out_ready cycle.
- Both counters saturate at 16'hFFFF; they do not wrap.
- State machine (states IDLE, RUN, DRAIN):
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → RUN when enable=1.
  - DRAIN → IDLE when s1_valid=0 and (out_valid=0, or out_valid && out_ready this cycle).
  - No pops occur in IDLE or DRAIN. Words already in S1/S2 always complete.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state=IDLE, s1_valid=0, out_valid=0;
  - out_op, out_key, out_index = 0;
  - req_count = drop_count = 0;
  - drained=1, fifo_rd_en=0.
- Reset mid-operation discards words in S1/S2; they are not re-pushed.
- Latency: a word popped at edge N is in S1 after N and in S2 after N+1, so out_valid is high from N+1.
- Throughput: one request per cycle while out_ready=1 and the FIFO is non-empty.
- While out_valid && !out_ready: out_op, out_key and out_index hold stable, and S1 holds.
  - fifo_rd_en=0 once S1 is full.
  - At most 2 words are in flight.
- Simultaneous events:
  - Pop and S1 advance in the same cycle: S1 takes the new word, with no bubble.
  - Drop and out handshake in the same cycle: both counters update as specified.
- First pop occurs in the cycle after the IDLE → RUN transition, i.e., the first edge with enable=1 changes only the state.
- drained is registered and follows the state.

## Test plan
- Reset, then enable=1 and FIFO presents 0x41 (insert, key 1) with out_ready=1: pop in cycle 1, out_valid in cycle 3 with out_op=01, out_key=1, out_index=9. req_count=1 after the handshake.
- Back-to-back FIFO words 0x02, 0x3F, 0x80 with out_ready=1: outputs at consecutive cycles:
  - (00, 2, index 2);
  - (00, 63, index 6);
  - (10, 0, index 0).
- out_ready=0 for 5 cycles while 4 words are queued: exactly 2 pops; outputs stable; no word lost or duplicated once out_ready=1.
- Words 0xC5, 0x41 (0xC5 malformed): drop_count=1, only the insert of key 1 is emitted, and req_count=1.
- enable dropped with 2 words in flight: no further pops. drained=1 after both handshakes; re-asserting enable resumes popping.
- Assert reset with out_valid=1: out_valid=0 and counters=0 immediately, without waiting for a clock edge.
